freq_meter: RTL and testbench

Reciprocal-free gated frequency meter that sits directly downstream of the programmable clock divider. It takes the divider's square-wave output (or any slow external signal) as `sig_in` and counts rising edges over a selectable gate window of 1 s, 100 ms, 10 ms or 1 ms at a 60 MHz system clock. The latched result is published on a one-cycle `valid` strobe and is readable byte-wise over the 8-bit TinyTapeout output bus, so the divider's setting can be checked on silicon without a scope.

---
 rtl/freq_meter_pkg.sv | 27 ++
 rtl/sync_edge_det.sv | 25 ++
 rtl/freq_meter.sv | 144 ++++++++++++++
 tb/tb_freq_meter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  localparam logic [1:0] GSEL_1S    = 2'd0;
  localparam logic [1:0] GSEL_100MS = 2'd1;
  localparam logic [1:0] GSEL_10MS  = 2'd2;
  localparam logic [1:0] GSEL_1MS   = 2'd3;

  // Window length in system clocks for a given gate selection.
  function automatic int unsigned gate_len(input int unsigned clk_hz, input logic [1:0] gsel);
    int unsigned n;
    case (gsel)
      GSEL_1S:    n = clk_hz;
      GSEL_100MS: n = clk_hz / 10;
      GSEL_10MS:  n = clk_hz / 100;
      default:    n = clk_hz / 1000;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus delay flop; flags a rising edge of an asynchronous pin.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_c_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= sig_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_c_o = s2_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter with selectable window, latched result and byte readout.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 60_000_000,
  parameter int unsigned CNT_W  = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       gate_sel,
  input  logic             sig_in,
  input  logic [1:0]       rd_sel,
  output logic [CNT_W-1:0] result,
  output logic             valid,
  output logic             ovf,
  output logic             busy,
  output logic [7:0]       dout
);

  localparam int unsigned GW = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic [1:0]       gsel_q, gsel_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             rise;
  logic [GW-1:0]    gate_load;
  logic [CNT_W-1:0] cnt_inc;
  logic             inc_sat;
  logic [30:0]      res_ext;

  sync_edge_det u_sync (
    .clk      (clk),
    .rst      (rst),
    .sig_i    (sig_in),
    .rise_c_o (rise)
  );

  assign gate_load = GW'(gate_len(CLK_HZ, gate_sel) - 1);
  assign inc_sat   = rise & (cnt_q == CNT_MAX);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(rise);

  // Window sequencing; terminal cycle folds in its own edge and reloads with no gap.
  always_comb begin
    state_d  = state_q;
    gate_d   = gate_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    gsel_d   = gsel_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gate_d = '0;
        cnt_d  = '0;
        sat_d  = 1'b0;
        if (en) state_d = ST_ARM;
      end
      ST_ARM: begin
        gsel_d  = gate_sel;
        gate_d  = gate_load;
        cnt_d   = '0;
        sat_d   = 1'b0;
        state_d = en ? ST_COUNT : ST_IDLE;
      end
      ST_COUNT: begin
        if (!en) begin
          state_d = ST_IDLE;
          gate_d  = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (gate_q == '0) begin
          result_d = cnt_inc;
          ovf_d    = sat_q | inc_sat;
          valid_d  = 1'b1;
          gate_d   = gate_load;
          gsel_d   = gate_sel;
          cnt_d    = '0;
          sat_d    = 1'b0;
        end else if (gate_sel != gsel_q) begin
          state_d = ST_ARM;
        end else begin
          cnt_d  = cnt_inc;
          sat_d  = sat_q | inc_sat;
          gate_d = gate_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_COUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gate_q   <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      gsel_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gate_q   <= gate_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      gsel_q   <= gsel_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Byte readout; top byte carries the overflow flag above any upper result bits.
  assign res_ext = 31'(result_q);

  always_comb begin
    dout = 8'h00;
    case (rd_sel)
      2'd0:    dout = res_ext[7:0];
      2'd1:    dout = res_ext[15:8];
      2'd2:    dout = res_ext[23:16];
      default: dout = {ovf_q, res_ext[30:24]};
    endcase
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: vector table plus scoreboard of expected strobes (value and cycle).
module tb_freq_meter;

  localparam int unsigned CLK_HZ = 10_000;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] gate_sel, rd_sel;
  logic       sig_in = 1'b0;

  logic [25:0] result0;
  logic        valid0, ovf0, busy0;
  logic [7:0]  dout0;
  logic [5:0]  result1;
  logic        valid1, ovf1, busy1;
  logic [7:0]  dout1;

  always #5 clk = ~clk;

  freq_meter #(.CLK_HZ(CLK_HZ), .CNT_W(26)) dut0 (
    .clk(clk), .rst(rst), .en(en), .gate_sel(gate_sel), .sig_in(sig_in), .rd_sel(rd_sel),
    .result(result0), .valid(valid0), .ovf(ovf0), .busy(busy0), .dout(dout0)
  );

  freq_meter #(.CLK_HZ(CLK_HZ), .CNT_W(6)) dut1 (
    .clk(clk), .rst(rst), .en(en), .gate_sel(gate_sel), .sig_in(sig_in), .rd_sel(rd_sel),
    .result(result1), .valid(valid1), .ovf(ovf1), .busy(busy1), .dout(dout1)
  );

  typedef struct {
    int unsigned res;
    bit          ovf;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  gsel;
    int unsigned hp;
    logic        lvl;
    int unsigned k;
    int unsigned res;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[6];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  int unsigned hp = 0;
  int unsigned ph = 0;
  logic        lvl = 1'b0;
  bit          restart = 1'b0;

  always @(posedge clk) cyc++;

  // Signal source: static level, or a square wave with half-period hp clocks.
  initial forever begin
    @(negedge clk);
    if (restart) begin
      restart = 1'b0;
      ph = 0;
      sig_in = 1'b0;
    end else if (hp == 0) begin
      sig_in = lvl;
    end else if (ph >= hp - 1) begin
      ph = 0;
      sig_in = ~sig_in;
    end else begin
      ph++;
    end
  end

  function automatic int unsigned glen(input logic [1:0] g);
    case (g)
      2'd0:    return 10000;
      2'd1:    return 1000;
      2'd2:    return 100;
      default: return 10;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned res, input int unsigned c);
    exp_t e0, e1;
    e0 = '{res, 1'b0, c};
    e1 = (res > 63) ? '{63, 1'b1, c} : '{res, 1'b0, c};
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic wait_drain(input int unsigned budget);
    for (int i = 0; i < int'(budget); i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL strobe timeout: %0d/%0d strobes outstanding, required 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0 unexpected valid: result %0d at cycle %0d, required no strobe", result0, cyc);
      end else begin
        e = q0.pop_front();
        chk("dut0 result", longint'(result0), longint'(e.res));
        chk("dut0 ovf", longint'(ovf0), longint'(e.ovf));
        chk("dut0 valid cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected valid: result %0d at cycle %0d, required no strobe", result1, cyc);
      end else begin
        e = q1.pop_front();
        chk("dut1 result", longint'(result1), longint'(e.res));
        chk("dut1 ovf", longint'(ovf1), longint'(e.ovf));
        chk("dut1 valid cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  initial begin
    int unsigned e, n, v;
    logic [7:0] rd0 [4];
    logic [7:0] rd1 [4];

    rst = 1'b1;
    en = 1'b0;
    gate_sel = 2'd0;
    rd_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset result", longint'(result0), 0);
    chk("reset valid", longint'(valid0), 0);
    chk("reset busy", longint'(busy0), 0);
    chk("reset ovf", longint'(ovf0), 0);
    chk("reset dout", longint'(dout0), 0);
    chk("reset result w6", longint'(result1), 0);
    rst = 1'b0;

    //          gsel  hp  lvl   k  result
    vecs[0] = '{2'd2, 5, 1'b0, 3, 10};
    vecs[1] = '{2'd3, 0, 1'b0, 3, 0};
    vecs[2] = '{2'd3, 0, 1'b1, 3, 0};
    vecs[3] = '{2'd2, 2, 1'b0, 2, 25};
    vecs[4] = '{2'd0, 5, 1'b0, 1, 1000};
    vecs[5] = '{2'd1, 1, 1'b0, 2, 500};

    foreach (vecs[i]) begin
      gate_sel = vecs[i].gsel;
      hp = vecs[i].hp;
      lvl = vecs[i].lvl;
      repeat (6) @(negedge clk);
      en = 1'b1;
      e = cyc;
      n = glen(vecs[i].gsel);
      for (int k = 0; k < int'(vecs[i].k); k++) push(vecs[i].res, e + n + 2 + n * k);
      wait_drain(n * (vecs[i].k + 1) + 20);
      en = 1'b0;
      repeat (3) @(negedge clk);
    end

    // Held results after the saturating run: 500 and 63/ovf.
    rd0 = '{8'hF4, 8'h01, 8'h00, 8'h00};
    rd1 = '{8'h3F, 8'h00, 8'h00, 8'h80};
    for (int r = 0; r < 4; r++) begin
      rd_sel = 2'(r);
      #1;
      chk($sformatf("dout rd_sel=%0d", r), longint'(dout0), longint'(rd0[r]));
      chk($sformatf("dout w6 rd_sel=%0d", r), longint'(dout1), longint'(rd1[r]));
    end
    @(negedge clk);

    // Gate change 2->3 at window cycle 40: window dropped, next strobe 12 cycles later.
    gate_sel = 2'd2;
    hp = 5;
    repeat (6) @(negedge clk);
    en = 1'b1;
    e = cyc;
    v = e + 102;
    push(10, v);
    while (cyc < v + 39) @(negedge clk);
    gate_sel = 2'd3;
    push(1, v + 51);
    while (cyc < v + 45) @(negedge clk);
    chk("result held after abort", longint'(result0), 10);
    wait_drain(100);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset at window cycle 50; restart is N+2 after reset release.
    rd_sel = 2'd0;
    gate_sel = 2'd2;
    repeat (6) @(negedge clk);
    en = 1'b1;
    e = cyc;
    v = e + 102;
    push(10, v);
    while (cyc < v + 40) @(negedge clk);
    chk("busy mid-window", longint'(busy0), 1);
    while (cyc < v + 47) @(negedge clk);
    restart = 1'b1;
    while (cyc < v + 49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post-rst result", longint'(result0), 0);
    chk("post-rst busy", longint'(busy0), 0);
    chk("post-rst dout", longint'(dout0), 0);
    chk("post-rst valid", longint'(valid0), 0);
    rst = 1'b0;
    push(10, v + 152);
    wait_drain(200);
    en = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
